// File: rtl/seven_segment_encoder.sv
// Recovers a hex digit from an active-low 7-segment pattern once it has been stable,
// and offers it on a valid/ready output with pattern-error and overrun reporting.
module seven_segment_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       code_ready,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       pattern_err,
    output logic       overrun,
    output logic       fsm_state
);

    // Output handshake: a digit transfers on every rising edge where code_valid
    // and code_ready are both high; code_out/code_valid stay put until then,
    // and code_ready has no effect while code_valid is low.

    localparam logic       TRACK   = 1'b0;
    localparam logic       HOLD    = 1'b1;
    localparam logic [6:0] BLANK   = 7'h7F;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic       state;
    logic [6:0] seg_q;
    logic [6:0] last_pat;
    logic [7:0] cnt;
    logic       changed;
    logic       qualify;
    logic [4:0] dec;

    // Returns {legal, digit}; legal is low for blank and all unlisted patterns.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h01:   decode = {1'b1, 4'h0};
            7'h4F:   decode = {1'b1, 4'h1};
            7'h12:   decode = {1'b1, 4'h2};
            7'h06:   decode = {1'b1, 4'h3};
            7'h4C:   decode = {1'b1, 4'h4};
            7'h24:   decode = {1'b1, 4'h5};
            7'h20:   decode = {1'b1, 4'h6};
            7'h0F:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h04:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h60:   decode = {1'b1, 4'hB};
            7'h31:   decode = {1'b1, 4'hC};
            7'h42:   decode = {1'b1, 4'hD};
            7'h30:   decode = {1'b1, 4'hE};
            7'h38:   decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    assign changed   = (seg_in != seg_q);
    assign qualify   = !changed && (cnt == CNT_MAX) && (seg_q != last_pat);
    assign dec       = decode(seg_q);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= TRACK;
            seg_q       <= BLANK;
            last_pat    <= BLANK;
            cnt         <= 8'd0;
            code_out    <= 4'd0;
            code_valid  <= 1'b0;
            pattern_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pattern_err <= 1'b0;
            if (changed) begin
                seg_q <= seg_in;
                cnt   <= 8'd0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end

            case (state)
                TRACK: begin
                    if (qualify) begin
                        last_pat <= seg_q;
                        if (dec[4]) begin
                            code_out   <= dec[3:0];
                            code_valid <= 1'b1;
                            state      <= HOLD;
                        end else if (seg_q != BLANK) begin
                            pattern_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (changed) overrun <= 1'b1;
                    // Acceptance restarts the stability window from this edge.
                    if (code_valid && code_ready) begin
                        code_valid <= 1'b0;
                        cnt        <= 8'd0;
                        state      <= TRACK;
                    end
                end
                default: state <= TRACK;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_encoder.sv
// Bench for seven_segment_encoder: directed scenarios plus random pattern runs,
// checked every cycle against a history-window reference model.
module tb_seven_segment_encoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       code_ready;
    logic [3:0] code_out;
    logic       code_valid;
    logic       pattern_err;
    logic       overrun;
    logic       fsm_state;

    int checks = 0;
    int errors = 0;

    seven_segment_encoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .code_ready  (code_ready),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .pattern_err (pattern_err),
        .overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Display table: index is the digit, entry is its active-low pattern.
    logic [6:0] pat_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model: a pattern qualifies when the last S+1 samples agree and
    // that window starts no earlier than reset or the last acceptance.
    logic [6:0] hist[$];
    int         barrier;
    logic [6:0] m_last;
    logic [3:0] m_code;
    logic       m_valid, m_err, m_ovr;

    int         emit_cnt, err_cnt;
    logic [3:0] last_emit;
    logic       prev_valid;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(7'h7F);
        barrier = 0;
        m_last  = 7'h7F;
        m_code  = 4'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        prev_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [6:0] seg, input logic rdy);
        int n;
        int idx;
        bit q;
        hist.push_back(seg);
        n = hist.size() - 1;
        m_err = 1'b0;
        if (m_valid) begin
            if (seg != hist[n-1]) m_ovr = 1'b1;
            if (rdy) begin
                m_valid = 1'b0;
                barrier = n;
            end
        end else begin
            q = (n - S >= barrier);
            if (q) for (int k = n - S; k < n; k++) if (hist[k] != seg) q = 0;
            if (q && seg != m_last) begin
                m_last = seg;
                idx = lookup(seg);
                if (idx >= 0) begin
                    m_code  = 4'(idx);
                    m_valid = 1'b1;
                end else if (seg != 7'h7F) begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("code_valid",  {7'd0, code_valid},  {7'd0, m_valid});
        chk("code_out",    {4'd0, code_out},    {4'd0, m_code});
        chk("pattern_err", {7'd0, pattern_err}, {7'd0, m_err});
        chk("overrun",     {7'd0, overrun},     {7'd0, m_ovr});
        chk("fsm_state",   {7'd0, fsm_state},   {7'd0, m_valid});
    endtask

    // Called at a falling edge; drives n cycles and checks after each rising edge.
    task automatic step(input logic [6:0] seg, input logic rdy, input int n);
        for (int c = 0; c < n; c++) begin
            seg_in     = seg;
            code_ready = rdy;
            @(posedge clk);
            model_edge(seg, rdy);
            @(negedge clk);
            compare_all();
            if (code_valid && !prev_valid) begin
                emit_cnt++;
                last_emit = code_out;
            end
            if (pattern_err) err_cnt++;
            prev_valid = code_valid;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst        = 1'b1;
        seg_in     = 7'h7F;
        code_ready = 1'b0;
        model_reset();
        #3;
        chk("reset_valid",   {7'd0, code_valid},  8'd0);
        chk("reset_overrun", {7'd0, overrun},     8'd0);
        chk("reset_code",    {4'd0, code_out},    8'd0);
        chk("reset_err",     {7'd0, pattern_err}, 8'd0);
        @(negedge clk);
        do_reset();

        // Digit 2 held after reset: one emit, no repeat
        emit_cnt = 0;
        step(7'h12, 1'b1, 10);
        chk("d2_emits", 8'(emit_cnt), 8'd1);
        chk("d2_code",  {4'd0, last_emit}, 8'h2);

        // Short-lived 2 never qualifies, then 1
        step(7'h7F, 1'b1, 6);
        emit_cnt = 0;
        step(7'h12, 1'b1, 3);
        step(7'h4F, 1'b1, 12);
        chk("d1_emits", 8'(emit_cnt), 8'd1);
        chk("d1_code",  {4'd0, last_emit}, 8'h1);

        // F, blank, F again: emitted twice
        emit_cnt = 0;
        step(7'h38, 1'b1, 6);
        step(7'h7F, 1'b1, 5);
        step(7'h38, 1'b1, 6);
        chk("f_twice_emits", 8'(emit_cnt), 8'd2);
        chk("f_twice_code",  {4'd0, last_emit}, 8'hF);

        // Illegal pattern: single error pulse, no digit
        emit_cnt = 0;
        err_cnt  = 0;
        step(7'h55, 1'b1, 10);
        chk("illegal_err_cycles", 8'(err_cnt), 8'd1);
        chk("illegal_emits", 8'(emit_cnt), 8'd0);

        // Change during HOLD sets overrun; 0 follows after acceptance
        step(7'h7F, 1'b0, 6);
        emit_cnt = 0;
        step(7'h00, 1'b0, 6);
        step(7'h01, 1'b0, 4);
        chk("hold_code",    {4'd0, code_out}, 8'h8);
        chk("hold_overrun", {7'd0, overrun},  8'd1);
        step(7'h01, 1'b1, 8);
        chk("after_hold_emits", 8'(emit_cnt), 8'd2);
        chk("after_hold_code",  {4'd0, last_emit}, 8'h0);

        // Asynchronous reset in HOLD
        step(7'h7F, 1'b0, 6);
        step(7'h00, 1'b0, 6);
        step(7'h01, 1'b0, 2);
        chk("pre_rst_valid", {7'd0, code_valid}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid",   {7'd0, code_valid}, 8'd0);
        chk("async_rst_overrun", {7'd0, overrun},    8'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        emit_cnt = 0;
        step(7'h00, 1'b1, 8);
        chk("post_rst_emits", 8'(emit_cnt), 8'd1);
        chk("post_rst_code",  {4'd0, last_emit}, 8'h8);

        // Random pattern runs with random consumer stalls
        for (int t = 0; t < 250; t++) begin
            int r;
            int len;
            logic [6:0] seg;
            r = $urandom_range(0, 19);
            if (r < 16)      seg = pat_tab[r];
            else if (r < 18) seg = 7'h7F;
            else             seg = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) step(seg, ($urandom_range(0, 3) != 0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_encoder.md
SEVEN_SEGMENT_ENCODER -- requirements
Module: seven_segment_encoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive unchanged cycles before a pattern is accepted; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port seg_in, input, 7, segment pattern {a,b,c,d,e,f,g}, active-low (0 = segment lit).
REQ-005 SHALL have port code_ready, input, 1, consumer accepts code_out when high with code_valid.
REQ-006 SHALL have port code_out, output, 4, recovered hex digit.
REQ-007 SHALL have port code_valid, output, 1, code_out holds a new digit awaiting acceptance.
REQ-008 SHALL have port pattern_err, output, 1, one-cycle pulse when a stable pattern is not a legal digit and not blank.
REQ-009 SHALL have port overrun, output, 1, sticky flag set when seg_in changes while a digit awaits acceptance.

Function
REQ-010 SHALL decode the inverse of the team display table, using seg_in hex to code: 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7, 00->8, 04->9, 08->A, 60->B, 31->C, 42->D, 30->E, 38->F.
REQ-011 SHALL treat 7'h7F as blank; every other unlisted pattern is illegal.
REQ-012 SHALL register seg_in into seg_q; whenever seg_in differs from seg_q, load seg_q and clear the 8-bit stability counter cnt; otherwise increment cnt, saturating at STABLE_CYCLES-1.
REQ-013 SHALL qualify seg_q as stable on the edge after cnt has reached STABLE_CYCLES-1 with seg_in still equal to seg_q; a new pattern first sampled at edge E0 and held qualifies at edge E0+STABLE_CYCLES.
REQ-014 SHALL act on a stable pattern only if it differs from last_pat (the last acted-on pattern), then load last_pat with it; the same pattern held indefinitely SHALL act exactly once.
REQ-015 SHALL implement FSM states TRACK and HOLD; reset state is TRACK.
REQ-016 In TRACK, a qualifying legal digit SHALL load code_out, set code_valid, and move to HOLD on the same edge.
REQ-017 In TRACK, a qualifying illegal pattern SHALL pulse pattern_err for exactly one cycle, leave code_valid low, and stay in TRACK.
REQ-018 In TRACK, a qualifying blank SHALL produce no output and stay in TRACK, so a repeated digit separated by blank is emitted again.
REQ-019 In HOLD, code_out and code_valid SHALL stay constant until the cycle code_valid and code_ready are both high; on that edge clear code_valid and return to TRACK with cnt cleared.
REQ-020 In HOLD, seg_q SHALL keep tracking seg_in but no pattern SHALL qualify; any seg_in change in HOLD SHALL set overrun.
REQ-021 overrun SHALL clear only on reset.
REQ-022 code_ready while code_valid is low SHALL have no effect.
REQ-023 Latency: a held legal digit after a blank SHALL assert code_valid STABLE_CYCLES+1 edges after seg_in changes (STABLE_CYCLES edges after E0).

Reset
REQ-024 On rst high, immediately and independent of clk: state TRACK, seg_q 7'h7F, last_pat 7'h7F, cnt 0, code_out 0, code_valid 0, pattern_err 0, overrun 0.
REQ-025 Reset asserted in HOLD SHALL drop code_valid at once and discard the pending digit.
REQ-026 After rst deasserts, the first qualifying non-blank pattern SHALL act normally.

Verification
REQ-027 After reset, seg_in 7'h12 held 10 cycles, code_ready=1 -> code_valid for exactly 1 cycle at E0+4 with code_out 2; no further valid.
REQ-028 seg_in 7'h12 for 3 cycles, then 7'h4F held -> no output for 12; code_out 1 once 4 edges after 7'h4F is first sampled.
REQ-029 Digit 7'h38, then blank 7'h7F for 5 cycles, then 7'h38 -> code_out F emitted twice.
REQ-030 seg_in 7'h55 held -> pattern_err high exactly one cycle; code_valid stays 0.
REQ-031 code_ready=0, seg_in 7'h00, then 7'h01 during HOLD -> code_out 8 held steady, overrun=1; raising code_ready -> accepted; 7'h01 then emits 0 four edges later.
REQ-032 rst asserted mid-HOLD between clock edges -> code_valid and overrun 0 before the next edge; 7'h00 re-applied after release -> 8 emitted.
